// File: rtl/param_data_memory_if.sv
// Request/response bundle between the memory-access stage and the data memory.
// The master side issues requests and clear pulses; the slave side is the memory.
interface param_data_memory_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 28
);
    localparam int BE_W = DATA_W / 8;

    logic              clr;
    logic              busy;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output clr,
        output req_valid,
        output req_wr,
        output req_addr,
        output req_wdata,
        output req_be,
        output rsp_ready,
        input  busy,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  clr,
        input  req_valid,
        input  req_wr,
        input  req_addr,
        input  req_wdata,
        input  req_be,
        input  rsp_ready,
        output busy,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/param_data_memory.sv
// Word-addressed data memory with a registered read port, byte-lane writes,
// range checking and a zeroing engine that runs after reset or on request.
module param_data_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 28,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    param_data_memory_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic              busy;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              req_ready;
    logic              accept;
    logic              drain;
    logic              take_clr;
    logic              do_write;

    // Any set bit above the implemented index range marks the access illegal.
    generate
        if (ADDR_W > IDX_W) begin : g_hi
            assign in_range = ~|bus.req_addr[ADDR_W-1:IDX_W];
        end else begin : g_full
            assign in_range = 1'b1;
        end
    endgenerate

    assign idx = bus.req_addr[IDX_W-1:0];

    // One-entry response slot: a new request fits if the slot is empty or
    // drains this cycle. A clear request blocks acceptance outright.
    assign req_ready = (state == IDLE) && !bus.clr
                    && (!rsp_valid || bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;
    assign drain     = rsp_valid && bus.rsp_ready;
    assign take_clr  = (state == IDLE) && bus.clr && !rsp_valid;
    assign do_write  = accept && bus.req_wr && in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + ONE;
                    if (clr_cnt == LAST) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        clr_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (take_clr) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= !in_range;
                        if (in_range && !bus.req_wr) begin
                            rsp_rdata <= mem[idx];
                        end else begin
                            rsp_rdata <= '0;
                        end
                    end else if (drain) begin
                        rsp_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // The array has no reset; the CLEAR state is what zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt[IDX_W-1:0]] <= '0;
        end else if (do_write) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.req_be[b]) begin
                    mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign bus.busy      = busy;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;

    a_rsp_hold: assert property (
        @(posedge clk) disable iff (rst)
        rsp_valid && !bus.rsp_ready
        |=> rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)
    );

    a_no_accept_busy: assert property (
        @(posedge clk) disable iff (rst)
        busy |-> !req_ready
    );
endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: directed scenarios plus random
// traffic checked against an array model of the memory and a cycle model.
module tb_param_data_memory;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 28;
    localparam int DEPTH  = 256;
    localparam int BE_W   = DATA_W / 8;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [27:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    param_data_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    param_data_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    req_t reqs[$];

    logic [31:0] mem_m [DEPTH];
    int          clr_left = DEPTH;
    bit          slot = 1'b0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic chk_got(input string name, input int i,
                           input logic [31:0] d, input logic e);
        if (i >= got_q.size()) begin
            checks++;
            fails++;
            $display("FAIL %s: response %0d missing, only %0d seen",
                     name, i, got_q.size());
        end else begin
            chk({name, "_data"}, got_q[i].data, d);
            chk({name, "_err"}, 32'(got_q[i].err), 32'(e));
        end
    endtask

    // Monitor: cycle model of busy/ready/valid plus the response scoreboard.
    always @(negedge clk) begin
        bit   exp_busy;
        bit   exp_ready;
        bit   drain;
        bit   acc;
        bit   slot_old;
        rsp_t r;
        int   a;
        if (rst) begin
            exp_q.delete();
            slot     = 1'b0;
            clr_left = DEPTH;
            foreach (mem_m[i]) mem_m[i] = '0;
        end else begin
            exp_busy  = (clr_left > 0);
            exp_ready = !exp_busy && !bus.clr && (!slot || bus.rsp_ready);
            chk("busy", 32'(bus.busy), 32'(exp_busy));
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(slot));
            if (slot && exp_q.size() > 0) begin
                chk("rsp_rdata", bus.rsp_rdata, exp_q[0].data);
                chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
            end
            drain    = slot && bus.rsp_ready;
            acc      = exp_ready && bus.req_valid;
            slot_old = slot;
            if (drain) begin
                r.data = bus.rsp_rdata;
                r.err  = bus.rsp_err;
                got_q.push_back(r);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (acc) begin
                a = int'(bus.req_addr);
                r.data = '0;
                r.err  = 1'b0;
                if (a >= DEPTH) begin
                    r.err = 1'b1;
                end else if (bus.req_wr) begin
                    for (int b = 0; b < BE_W; b++)
                        if (bus.req_be[b])
                            mem_m[a][8*b +: 8] = bus.req_wdata[8*b +: 8];
                end else begin
                    r.data = mem_m[a];
                end
                exp_q.push_back(r);
            end
            slot = acc ? 1'b1 : (drain ? 1'b0 : slot);
            if (exp_busy) begin
                clr_left--;
            end else if (bus.clr && !slot_old) begin
                clr_left = DEPTH;
                foreach (mem_m[i]) mem_m[i] = '0;
            end
        end
    end

    function automatic req_t mk(input logic wr, input logic [27:0] addr,
                                input logic [31:0] d, input logic [3:0] be);
        req_t q;
        q.wr    = wr;
        q.addr  = addr;
        q.wdata = d;
        q.be    = be;
        return q;
    endfunction

    // Issues the queued requests back to back, holding each until accepted.
    task automatic burst(output int cyc);
        int n;
        cyc = 0;
        foreach (reqs[i]) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = reqs[i].wr;
            bus.req_addr  = reqs[i].addr;
            bus.req_wdata = reqs[i].wdata;
            bus.req_be    = reqs[i].be;
            n = 0;
            do begin
                @(negedge clk);
                cyc++;
                n++;
            end while (!bus.req_ready && n < 300);
            if (!bus.req_ready) begin
                checks++;
                fails++;
                $display("FAIL burst_timeout: request %0d not accepted", i);
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        reqs.delete();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cyc;
        int stalls;
        bus.clr       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        count_busy(n);
        chk("reset_busy_len", 32'(n), 32'd256);

        @(posedge clk); #1;
        got_q.delete();
        reqs.push_back(mk(0, 28'h00, 0, 0));
        reqs.push_back(mk(0, 28'hFF, 0, 0));
        burst(cyc);
        settle(3);
        chk_got("rd_0_after_clear", 0, 32'h0, 1'b0);
        chk_got("rd_ff_after_clear", 1, 32'h0, 1'b0);

        got_q.delete();
        reqs.push_back(mk(1, 28'h10, 32'hDEADBEEF, 4'b1111));
        reqs.push_back(mk(0, 28'h10, 0, 0));
        burst(cyc);
        chk("wr_rd_cycles", 32'(cyc), 32'd2);
        settle(3);
        chk_got("wr_ack", 0, 32'h0, 1'b0);
        chk_got("rd_after_wr", 1, 32'hDEADBEEF, 1'b0);

        got_q.delete();
        reqs.push_back(mk(1, 28'h10, 32'h11223344, 4'b0101));
        reqs.push_back(mk(0, 28'h10, 0, 0));
        burst(cyc);
        settle(3);
        chk_got("partial_wr_ack", 0, 32'h0, 1'b0);
        chk_got("partial_wr_rd", 1, 32'hDE22BE44, 1'b0);

        got_q.delete();
        reqs.push_back(mk(0, 28'h100, 0, 0));
        reqs.push_back(mk(0, 28'h000, 0, 0));
        reqs.push_back(mk(1, 28'hFFFFFFF, 32'hAAAAAAAA, 4'b1111));
        reqs.push_back(mk(0, 28'h0FF, 0, 0));
        burst(cyc);
        settle(3);
        chk_got("oor_rd", 0, 32'h0, 1'b1);
        chk_got("rd_0_after_oor", 1, 32'h0, 1'b0);
        chk_got("oor_wr", 2, 32'h0, 1'b1);
        chk_got("rd_ff_after_oor_wr", 3, 32'h0, 1'b0);

        got_q.delete();
        bus.rsp_ready = 1'b0;
        reqs.push_back(mk(0, 28'h10, 0, 0));
        burst(cyc);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 28'h05;
        stalls = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.req_ready) stalls++;
        end
        chk("stall_ready_cnt", 32'(stalls), 32'd0);
        chk("stall_rdata", bus.rsp_rdata, 32'hDE22BE44);
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        reqs.push_back(mk(0, 28'h10, 0, 0));
        reqs.push_back(mk(0, 28'h00, 0, 0));
        reqs.push_back(mk(0, 28'h10, 0, 0));
        reqs.push_back(mk(0, 28'h05, 0, 0));
        burst(cyc);
        chk("throughput_cycles", 32'(cyc), 32'd4);
        settle(3);
        chk_got("stalled_rsp", 0, 32'hDE22BE44, 1'b0);
        chk_got("b2b_0", 1, 32'hDE22BE44, 1'b0);
        chk_got("b2b_1", 2, 32'h0, 1'b0);
        chk_got("b2b_2", 3, 32'hDE22BE44, 1'b0);
        chk_got("b2b_3", 4, 32'h0, 1'b0);

        got_q.delete();
        reqs.push_back(mk(1, 28'h05, 32'hA5A5A5A5, 4'b1111));
        reqs.push_back(mk(0, 28'h05, 0, 0));
        burst(cyc);
        settle(2);
        chk_got("fill_5", 1, 32'hA5A5A5A5, 1'b0);
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        count_busy(n);
        chk("clr_busy_len", 32'(n), 32'd256);
        @(posedge clk); #1;
        got_q.delete();
        reqs.push_back(mk(0, 28'h05, 0, 0));
        reqs.push_back(mk(1, 28'h05, 32'h5A5A5A5A, 4'b1111));
        burst(cyc);
        settle(3);
        chk_got("rd_5_after_clr", 0, 32'h0, 1'b0);

        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        repeat (100) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        count_busy(n);
        chk("reset_mid_clr_busy_len", 32'(n), 32'd256);
        @(posedge clk); #1;
        got_q.delete();
        reqs.push_back(mk(0, 28'h05, 0, 0));
        burst(cyc);
        settle(3);
        chk_got("rd_5_after_rst_clr", 0, 32'h0, 1'b0);

        for (int c = 0; c < 3000; c++) begin
            bus.req_valid = ($urandom_range(0, 9) < 7);
            bus.req_wr    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                bus.req_addr = 28'($urandom_range(32'h0FFFFFFF, 256));
            else
                bus.req_addr = 28'($urandom_range(0, 255));
            bus.req_wdata = $urandom;
            bus.req_be    = 4'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            bus.clr       = ($urandom_range(0, 999) == 0);
            @(posedge clk); #1;
        end

        bus.req_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && clr_left == 0 && !slot) break;
        end
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end
endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
Parametrised single-port data memory for the RISC core's load/store path. It adds the following:
- a clock
- a registered read path
- a valid/ready request/response handshake
- per-byte write enables
- out-of-range address detection
- a hardware clear engine that zeroes the whole array one word per cycle, after reset or on request

It sits between the core's memory-access stage and the word-addressed data store.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8
ADDR_W, 28, width of the request address port (word address)
DEPTH, 256, number of words implemented; power of two, DEPTH <= 2**ADDR_W
IDX_W, $clog2(DEPTH), derived index width; not to be overridden

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  clear request, sampled in IDLE
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  DATA_W/8  byte enables; bit i controls bits [8i+7:8i]
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  address out of range
busy  out  1  clear engine running

Behaviour:
Interface:
- One clock, clk. Reset rst is asynchronous and active-high.

Reset (asynchronous):
- state = CLEAR, clr_cnt = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, req_ready = 0, busy = 1.
- Array contents are not reset directly; the CLEAR state zeroes them.

FSM states:
- CLEAR:
  - Writes 0 to memory[clr_cnt], then increments clr_cnt.
  - When clr_cnt == DEPTH-1 is written, goes to IDLE next cycle.
  - Takes exactly DEPTH cycles. busy = 1 and req_ready = 0 throughout.
- IDLE:
  - busy = 0.
  - req_ready = !rsp_valid || rsp_ready (one-entry response register; no overlap beyond that).
  - If clr == 1 and no response is pending (rsp_valid == 0), goes to CLEAR with clr_cnt = 0. That cycle, req_ready = 0.
  - clr has priority over a simultaneous req_valid.
  - If clr == 1 while a response is pending, the clear waits until the response drains.

Request acceptance (IDLE, req_valid && req_ready && !clr):
- Range check:
  - in range: req_addr[ADDR_W-1:IDX_W] == 0; index = req_addr[IDX_W-1:0].
  - out of range: next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, no array write.
- Read:
  - Next cycle rsp_valid = 1, rsp_rdata = memory[index], rsp_err = 0.
  - Latency is exactly 1 cycle.
- Write:
  - Updates only the enabled byte lanes at the clock edge.
  - Next cycle rsp_valid = 1, rsp_rdata = 0, rsp_err = 0 (write acknowledge).
  - req_be == 0 is legal: no change, acknowledge still issued.

Response channel:
- rsp_valid, rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready.
- On a drain cycle with no new accept, rsp_valid returns to 0 next cycle.
- Back-to-back operation: a new accept in the same cycle as a drain replaces the response, giving 1 op/cycle throughput with rsp_ready held high.

Hazards:
- A read issued in the cycle after a write to the same index returns the newly written data. The array write completes before the next edge.

Reset mid-operation:
- Asynchronous reset during CLEAR or IDLE aborts everything, drops any pending response, and restarts CLEAR from index 0.

Widths:
- clr_cnt is IDX_W+1 bits wide, so DEPTH-1 is reachable without wrap ambiguity.
- No arithmetic is applied to data.

Test Plan:
- Reset then idle, DEPTH=256 → busy = 1 and req_ready = 0 for exactly 256 cycles; busy = 0 on cycle 257; a read of addr 0x00 and of addr 0xFF both return 0x00000000, rsp_err = 0.
- Write addr 0x10, data 0xDEADBEEF, be = 4'b1111; then read 0x10 the next cycle → write ack (rdata 0, err 0), then rdata = 0xDEADBEEF with 1-cycle latency.
- Write 0x10, data 0x11223344, be = 4'b0101 over the previous value → read returns 0xDE22BE44.
- Read addr 0x100 with DEPTH=256 → rsp_err = 1, rsp_rdata = 0; a follow-up read of 0x00 is unchanged (0). Write to 0x0FFFFFFF → err = 1, array unchanged.
- Hold rsp_ready = 0 after a read → rsp_valid and rdata stay stable and req_ready = 0. Raise rsp_ready → response drains; with req_valid held, throughput is 1 op/cycle.
- Fill addr 5 = 0xA5A5A5A5, pulse clr for 1 cycle → busy = 1 for 256 cycles and read of 5 returns 0. Assert rst at cycle 100 of the clear → clear restarts, busy lasts 256 more cycles.
